// File: rtl/digit_serial_range_adder.sv
// rtl/digit_serial_range_adder.sv - digit-serial range-checked adder with valid/ready handshakes
// Optional build macro DIGIT_SERIAL_ADDER_SATURATE_EN: saturate result to all ones on final carry.
module digit_serial_range_adder #(
   parameter int          WIDTH    = 8,
   parameter int          DIGIT    = 2,
   parameter int unsigned OP_LIMIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             range_err
);

   localparam int N  = WIDTH / DIGIT;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]    K_LAST = KW'(N - 1);
   localparam logic [WIDTH-1:0] LIMIT  = WIDTH'(OP_LIMIT);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("digit_serial_range_adder: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   logic [1:0]       state;
   logic [KW-1:0]    k;
   logic             carry_q;
   logic [WIDTH-1:0] op1_q;
   logic [WIDTH-1:0] op2_q;
   logic [WIDTH-1:0] shadow;

   logic [DIGIT:0]   digit_sum;
   logic [WIDTH-1:0] shadow_next;
   logic [WIDTH-1:0] final_result;
   logic             out_of_range;

   assign in_ready     = (state == IDLE) && !rst;
   assign out_valid    = (state == DONE);
   assign out_of_range = (op1 > LIMIT) || (op2 > LIMIT);

   // Partial sums live only in shadow; result is written once, on entry to DONE.
   always_comb begin
      digit_sum   = {1'b0, op1_q[k*DIGIT +: DIGIT]} + {1'b0, op2_q[k*DIGIT +: DIGIT]}
                  + {{DIGIT{1'b0}}, carry_q};
      shadow_next = shadow;
      shadow_next[k*DIGIT +: DIGIT] = digit_sum[DIGIT-1:0];
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
      final_result = digit_sum[DIGIT] ? {WIDTH{1'b1}} : shadow_next;
`else
      final_result = shadow_next;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         carry_q   <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         shadow    <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         range_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op1_q   <= op1;
                  op2_q   <= op2;
                  k       <= '0;
                  carry_q <= 1'b0;
                  shadow  <= '0;
                  if (out_of_range) begin
                     state     <= DONE;
                     result    <= '0;
                     carry_out <= 1'b0;
                     range_err <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               shadow  <= shadow_next;
               carry_q <= digit_sum[DIGIT];
               k       <= k + 1'b1;
               if (k == K_LAST) begin
                  state     <= DONE;
                  result    <= final_result;
                  carry_out <= digit_sum[DIGIT];
                  range_err <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_serial_range_adder.sv
// tb/tb_digit_serial_range_adder.sv - table, sequence and random checks over three adder configurations
// Honours DIGIT_SERIAL_ADDER_SATURATE_EN in its expected values.
module tb_digit_serial_range_adder;

`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam int NDIG = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        out_ready;
   logic [15:0] op1, op2;
   logic        in_valid [3];
   logic        ir [3];
   logic        ov [3];
   logic        co [3];
   logic        re [3];
   logic [15:0] res [3];
   logic [7:0]  res0, res1;
   logic [15:0] res2;

   assign res[0] = {8'h00, res0};
   assign res[1] = {8'h00, res1};
   assign res[2] = res2;

   // config 0: defaults; config 1: range check disabled; config 2: 16-bit, 4-bit digits
   digit_serial_range_adder u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir[0]),
      .op1(op1[7:0]), .op2(op2[7:0]), .out_valid(ov[0]), .out_ready(out_ready),
      .result(res0), .carry_out(co[0]), .range_err(re[0]));

   digit_serial_range_adder #(.WIDTH(8), .DIGIT(2), .OP_LIMIT(255)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir[1]),
      .op1(op1[7:0]), .op2(op2[7:0]), .out_valid(ov[1]), .out_ready(out_ready),
      .result(res1), .carry_out(co[1]), .range_err(re[1]));

   digit_serial_range_adder #(.WIDTH(16), .DIGIT(4), .OP_LIMIT(65535)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir[2]),
      .op1(op1), .op2(op2), .out_valid(ov[2]), .out_ready(out_ready),
      .result(res2), .carry_out(co[2]), .range_err(re[2]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int cfg_width(input int s);
      return (s == 2) ? 16 : 8;
   endfunction

   function automatic longint cfg_limit(input int s);
      return (s == 0) ? 64'd15 : ((s == 1) ? 64'd255 : 64'd65535);
   endfunction

   // Reference: plain integer addition, range test and wrap/saturate; returns {err, carry, result}
   function automatic logic [17:0] model(input int s, input logic [15:0] a, input logic [15:0] b);
      longint mask, sum;
      logic   e, c;
      logic [15:0] r;
      mask = (64'd1 << cfg_width(s)) - 1;
      e = (longint'(a) > cfg_limit(s)) || (longint'(b) > cfg_limit(s));
      sum = longint'(a) + longint'(b);
      c = 1'b0;
      r = 16'h0;
      if (!e) begin
         c = (sum > mask);
         r = 16'(sum & mask);
         if (SAT && c) r = 16'(mask);
      end
      return {e, c, r};
   endfunction

   task automatic txn(input int s, input logic [15:0] a, input logic [15:0] b, input int stall,
                      input logic [15:0] er, input logic ec, input logic ee, input string tag);
      int lat;
      int w;
      logic ready_leak;
      w = 0;
      while (!ir[s] && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({tag, " in_ready_before_accept"}, 32'(ir[s]), 32'd1);
      op1 = a;
      op2 = b;
      in_valid[s] = 1'b1;
      out_ready = (stall == 0);
      @(negedge clk);
      // in_valid stays high with junk operands; the block must ignore it outside IDLE
      op1 = 16'($urandom);
      op2 = 16'($urandom);
      lat = 0;
      ready_leak = 1'b0;
      while (!ov[s] && lat < 20) begin
         if (ir[s]) ready_leak = 1'b1;
         @(negedge clk);
         lat++;
      end
      in_valid[s] = 1'b0;
      check({tag, " latency"}, 32'(lat), ee ? 32'd0 : 32'(NDIG));
      check({tag, " in_ready_busy"}, 32'(ready_leak | ir[s]), 32'd0);
      check({tag, " result"}, 32'(res[s]), 32'(er));
      check({tag, " carry_out"}, 32'(co[s]), 32'(ec));
      check({tag, " range_err"}, 32'(re[s]), 32'(ee));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, " stall_hold"}, {13'h0, ov[s], ir[s], co[s], res[s]}, {13'h0, 1'b1, 1'b0, ec, er});
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, " release"}, {30'h0, ov[s], ir[s]}, 32'h1);
   endtask

   typedef struct {
      int          s;
      logic [15:0] a, b;
      int          stall;
      logic [15:0] er;
      logic        ec, ee;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{0, 16'd5,      16'd9,      0, 16'd14, 1'b0, 1'b0};
      tbl[1] = '{0, 16'd16,     16'd1,      0, 16'd0,  1'b0, 1'b1};
      tbl[2] = '{0, 16'd15,     16'd15,     0, 16'd30, 1'b0, 1'b0};
      tbl[3] = '{1, 16'd200,    16'd100,    0, SAT ? 16'd255 : 16'd44, 1'b1, 1'b0};
      tbl[4] = '{0, 16'd3,      16'd4,      3, 16'd7,  1'b0, 1'b0};
      tbl[5] = '{2, 16'hFFFF,   16'h0001,   0, SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b0};
      tbl[6] = '{2, 16'h1234,   16'h4321,   0, 16'h5555, 1'b0, 1'b0};
      tbl[7] = '{0, 16'd0,      16'd0,      0, 16'd0,  1'b0, 1'b0};
      tbl[8] = '{0, 16'd15,     16'd16,     2, 16'd0,  1'b0, 1'b1};
      tbl[9] = '{1, 16'd255,    16'd255,    1, SAT ? 16'd255 : 16'd254, 1'b1, 1'b0};

      for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
      op1 = 16'h0;
      op2 = 16'h0;
      out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_cycle dut%0d", i), {30'h0, ir[i], ov[i]}, 32'h0);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("after_reset dut%0d", i), {12'h0, ir[i], ov[i], co[i], re[i], res[i]}, 32'h8_0000);
      end
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         txn(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].er, tbl[i].ec, tbl[i].ee,
             $sformatf("vec%0d", i));
      end

      // reset two cycles into RUN discards the transaction
      op1 = 16'd7;
      op2 = 16'd8;
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrun out_valid", 32'(ov[0]), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midrun reset_cycle", {30'h0, ir[0], ov[0]}, 32'h0);
      rst = 1'b0;
      #1;
      check("midrun idle_outputs", {12'h0, ir[0], ov[0], co[0], re[0], res[0]}, 32'h8_0000);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
         end
         check("midrun no_output", 32'(seen), 32'd0);
      end
      txn(0, 16'd1, 16'd2, 0, 16'd3, 1'b0, 1'b0, "post_reset");

      // randomized transactions against the reference model
      for (int i = 0; i < 45; i++) begin
         int s;
         logic [15:0] a, b;
         logic [17:0] m;
         s = i % 3;
         if (s == 0) begin
            a = 16'($urandom_range(0, 19));
            b = 16'($urandom_range(0, 19));
         end else if (s == 1) begin
            a = 16'($urandom_range(0, 255));
            b = 16'($urandom_range(0, 255));
         end else begin
            a = 16'($urandom);
            b = 16'($urandom);
         end
         m = model(s, a, b);
         txn(s, a, b, int'($urandom_range(0, 2)), m[15:0], m[16], m[17], $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
